comm_txbuf: RTL

- Upstream source for the BPSK transmit chain.
- Accepts 32-bit beats from a host/control write port and packs four beats into one 128-bit word.
- Stores packed words in a first-word-fall-through FIFO that presents the 128-bit data/empty/rd_en read interface consumed by the transmit path.
- Supports flush of a partial word, overflow detection and occupancy reporting.

---
 rtl/comm_txbuf_pkg.sv | 28 ++
 rtl/comm_txbuf_if.sv | 36 +++
 rtl/comm_txbuf_mem.sv | 77 +++++++
 rtl/comm_txbuf.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/comm_txbuf_pkg.sv
// ---------------------------------------------------------------------------
// comm_pkg : shared types and constants for the comm_txbuf transmit buffer.
//   BEAT_W / WORD_W / LANES describe the 4 x 32-bit -> 128-bit packing.
//   DEFAULT_PREAMBLE is the frame marker used when COMM_TXBUF_PREAMBLE_EN is
//   defined at build time.
//   pack_lane() drops one beat into its MSB-first lane of a word.
// ---------------------------------------------------------------------------
package comm_pkg;

  localparam int BEAT_W = 32;
  localparam int WORD_W = 128;
  localparam int LANES  = 4;
  localparam int LANE_W = $clog2(LANES);

  typedef logic [BEAT_W-1:0] beat_t;
  typedef logic [WORD_W-1:0] word_t;

  localparam word_t DEFAULT_PREAMBLE = 128'hA5A5_5A5A_F0F0_0F0F_CCCC_3333_FF00_00FF;

  // Lane 0 is the most significant beat of the word.
  function automatic word_t pack_lane(word_t w, beat_t b, logic [LANE_W-1:0] lane);
    word_t r;
    r = w;
    r[WORD_W-1-int'(lane)*BEAT_W -: BEAT_W] = b;
    return r;
  endfunction

endpackage

// File: rtl/comm_txbuf_if.sv
// ---------------------------------------------------------------------------
// comm_txbuf_if : host write port + FWFT read port of comm_txbuf.
//   master : host/consumer side (drives wr_valid, wr_data, flush, rd_en,
//            overflow_clr; observes wr_ready, din, empty, full, level,
//            overflow).
//   slave  : the buffer itself.
// ---------------------------------------------------------------------------
interface comm_txbuf_if
  import comm_pkg::*;
#(
  parameter int AW = 4
) ();

  logic        wr_valid;
  beat_t       wr_data;
  logic        wr_ready;
  logic        flush;
  logic        rd_en;
  word_t       din;
  logic        empty;
  logic        full;
  logic [AW:0] level;
  logic        overflow;
  logic        overflow_clr;

  modport master (
    output wr_valid, wr_data, flush, rd_en, overflow_clr,
    input  wr_ready, din, empty, full, level, overflow
  );

  modport slave (
    input  wr_valid, wr_data, flush, rd_en, overflow_clr,
    output wr_ready, din, empty, full, level, overflow
  );

endinterface

// File: rtl/comm_txbuf_mem.sv
// ---------------------------------------------------------------------------
// comm_txbuf_mem : 2**AW x 128-bit first-word-fall-through FIFO.
//   clk, rst_n : clock, async active-low reset
//   we_i       : write wdata_i this edge (caller guarantees room or a pop)
//   rd_en_i    : pop request, ignored while empty
//   dout_o     : registered head word, valid while empty_o = 0
//   empty_o / full_o / level_o : registered occupancy flags and count
// ---------------------------------------------------------------------------
module comm_txbuf_mem
  import comm_pkg::*;
#(
  parameter int AW = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we_i,
  input  word_t       wdata_i,
  input  logic        rd_en_i,
  output word_t       dout_o,
  output logic        empty_o,
  output logic        full_o,
  output logic [AW:0] level_o
);

  localparam int DEPTH = 2**AW;

  word_t         mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]   level_q, level_d;
  logic          empty_q, full_q, pop;
  word_t         dout_q, dout_d;

  assign pop = rd_en_i && !empty_q;

  always_comb begin
    wptr_d  = wptr_q + AW'(we_i);
    rptr_d  = rptr_q + AW'(pop);
    level_d = level_q + (AW+1)'(we_i) - (AW+1)'(pop);
    dout_d  = dout_q;
    // Head register tracks the new head; a write landing on it bypasses the
    // RAM. When the FIFO drains, the last word is simply held.
    if (level_d != '0)
      dout_d = (we_i && (wptr_q == rptr_d)) ? wdata_i : mem_q[rptr_d];
  end

  // NOTE: the storage array has no reset; only pointers and flags need one,
  // and leaving it out lets the array map onto RAM.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[wptr_q] <= wdata_i;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      dout_q  <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      empty_q <= (level_d == '0);
      full_q  <= (level_d == (AW+1)'(DEPTH));
      dout_q  <= dout_d;
    end
  end

  assign dout_o  = dout_q;
  assign empty_o = empty_q;
  assign full_o  = full_q;
  assign level_o = level_q;

endmodule

// File: rtl/comm_txbuf.sv
// ---------------------------------------------------------------------------
// comm_txbuf : packs 32-bit host beats MSB-first into 128-bit words and
// queues them in a FWFT FIFO for the BPSK transmit path.
//   CLK  : clock, rising edge
//   RST  : async active-low reset
//   bus  : comm_txbuf_if.slave (host write port, flush, FWFT read port,
//          occupancy and sticky overflow)
// Build option: COMM_TXBUF_PREAMBLE_EN inserts PREAMBLE ahead of the first
// data word of every frame (frame = beats after reset or a completed flush).
// ---------------------------------------------------------------------------
module comm_txbuf
  import comm_pkg::*;
#(
  parameter int    AW       = 4,
  parameter word_t PREAMBLE = DEFAULT_PREAMBLE
) (
  input  logic        CLK,
  input  logic        RST,
  comm_txbuf_if.slave bus
);

  logic        mem_empty, mem_full;
  logic [AW:0] mem_level;
  word_t       mem_dout;

  logic              pop, commit, pend_free, wr_ready, accept;
  logic              flush_req, flush_go, frame_start;
  logic [LANE_W:0]   fill;
  word_t             packed_w;

  logic [LANE_W-1:0] lane_q, lane_d;
  word_t             pack_q, pack_d;
  logic              pend_q, pend_d;
  word_t             pend_word_q, pend_word_d;
  logic              flush_hold_q, flush_hold_d;
  logic              ovf_q, ovf_d;

  // The holding register drains whenever the FIFO has room, including the
  // full case where the consumer frees a slot on the same edge.
  assign pop       = bus.rd_en && !mem_empty;
  assign commit    = pend_q && (!mem_full || pop);
  assign pend_free = !pend_q || commit;
  assign wr_ready  = !(pend_q && mem_full && !pop);
  assign accept    = bus.wr_valid && wr_ready;
  assign flush_req = bus.flush || flush_hold_q;

`ifdef COMM_TXBUF_PREAMBLE_EN
  logic frame_open_q, frame_open_d;

  assign frame_start = accept && !frame_open_q;

  always_comb begin
    frame_open_d = frame_open_q;
    if (flush_go)    frame_open_d = 1'b0;
    else if (accept) frame_open_d = 1'b1;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) frame_open_q <= 1'b0;
    else      frame_open_q <= frame_open_d;
  end
`else
  assign frame_start = 1'b0;
`endif

  // NOTE: every variable gets its default first, so no path through this
  // block can leave a value unassigned and infer a latch.
  always_comb begin
    packed_w     = pack_q;
    fill         = {1'b0, lane_q};
    pend_d       = pend_q && !commit;
    pend_word_d  = pend_word_q;
    flush_hold_d = 1'b0;
    ovf_d        = ovf_q;

    // The beat is packed before any flush padding is considered.
    if (accept) begin
      packed_w = pack_lane(pack_q, bus.wr_data, lane_q);
      fill     = fill + 1'b1;
    end
    lane_d = fill[LANE_W-1:0];
    pack_d = packed_w;

    // A flush can only close the word when the holding slot is free and not
    // already claimed by a preamble; otherwise it waits.
    flush_go = flush_req && (fill != '0) && (fill != (LANE_W+1)'(LANES))
               && pend_free && !frame_start;

    if (frame_start) begin
      pend_d      = 1'b1;
      pend_word_d = PREAMBLE;
    end

    if (fill == (LANE_W+1)'(LANES) || flush_go) begin
      // Unused lanes of pack_q are already zero, which is the padding.
      pend_d      = 1'b1;
      pend_word_d = packed_w;
      lane_d      = '0;
      pack_d      = '0;
    end else if (flush_req && (fill != '0)) begin
      flush_hold_d = 1'b1;
    end

    if (bus.overflow_clr)                ovf_d = 1'b0;
    else if (bus.wr_valid && !wr_ready)  ovf_d = 1'b1;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      lane_q       <= '0;
      pack_q       <= '0;
      pend_q       <= 1'b0;
      pend_word_q  <= '0;
      flush_hold_q <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      lane_q       <= lane_d;
      pack_q       <= pack_d;
      pend_q       <= pend_d;
      pend_word_q  <= pend_word_d;
      flush_hold_q <= flush_hold_d;
      ovf_q        <= ovf_d;
    end
  end

  comm_txbuf_mem #(.AW(AW)) u_mem (
    .clk     (CLK),
    .rst_n   (RST),
    .we_i    (commit),
    .wdata_i (pend_word_q),
    .rd_en_i (bus.rd_en),
    .dout_o  (mem_dout),
    .empty_o (mem_empty),
    .full_o  (mem_full),
    .level_o (mem_level)
  );

  assign bus.wr_ready = wr_ready;
  assign bus.din      = mem_dout;
  assign bus.empty    = mem_empty;
  assign bus.full     = mem_full;
  assign bus.level    = mem_level;
  assign bus.overflow = ovf_q;

endmodule
